fp32_to_posit: RTL and testbench



---
 rtl/posit_pkg.sv | 56 +++++
 rtl/posit_lzc.sv | 24 ++
 rtl/fp32_to_posit.sv | 176 +++++++++++++++++
 tb/tb_fp32_to_posit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/posit_pkg.sv
`default_nettype none
// ============================================================================
// posit_pkg : shared class encoding, pipeline payloads and pattern helpers
//             for the posit datapath.
// Rev 1.0
// ============================================================================
package posit_pkg;

  localparam int MAX_N   = 32;
  localparam int MAX_ES  = 3;
  localparam int FRAC_W  = 23;
  localparam int BS      = $clog2(MAX_N);
  localparam int SCALE_W = MAX_ES + BS + 2;
  localparam int RUN_W   = BS + 1;

  typedef enum logic [1:0] {
    PC_ZERO = 2'd0,
    PC_NORM = 2'd1,
    PC_NAR  = 2'd2
  } pclass_t;

  // Stage 1 -> 2: classified operand with unbiased binary scale
  typedef struct packed {
    pclass_t                    cls;
    logic                       sign;
    logic signed [SCALE_W-1:0]  scale;
    logic [FRAC_W-1:0]          frac;
  } unpack_t;

  // Stage 2 -> 3: regime run description and saturation decision
  typedef struct packed {
    pclass_t            cls;
    logic               sign;
    logic               sat_max;
    logic               sat_min;
    logic               k_neg;
    logic [RUN_W-1:0]   run;
    logic [MAX_ES-1:0]  e;
    logic [FRAC_W-1:0]  frac;
  } regime_t;

  function automatic logic [MAX_N-1:0] maxpos(input int n);
    return (MAX_N'(1) << (n - 1)) - MAX_N'(1);
  endfunction

  // Low bit of maxpos is always set, so this is simply 1 for any width
  function automatic logic [MAX_N-1:0] minpos(input int n);
    return maxpos(n) & MAX_N'(1);
  endfunction

  function automatic logic [MAX_N-1:0] nar_pat(input int n);
    return MAX_N'(1) << (n - 1);
  endfunction

endpackage : posit_pkg
`default_nettype wire

// File: rtl/posit_lzc.sv
`default_nettype none
// ============================================================================
// posit_lzc : parameterized leading-zero count; all-zero input returns W.
// Rev 1.0
// ============================================================================
module posit_lzc #(
  parameter int W = 23
) (
  input  logic [W-1:0]           in_bits,
  output logic [$clog2(W+1)-1:0] count
);

  localparam int CW = $clog2(W + 1);

  // Ascending scan: the highest set bit is the last one written
  always_comb begin
    count = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (in_bits[i]) count = CW'(W - 1 - i);
    end
  end

endmodule : posit_lzc
`default_nettype wire

// File: rtl/fp32_to_posit.sv
`default_nettype none
// ============================================================================
// fp32_to_posit : 3-stage IEEE-754 binary32 -> posit<N,ES> converter with
//                 valid/ready back-pressure. FP32_TO_POSIT_INEXACT_EN adds out_inexact.
// Rev 1.0
// ============================================================================
module fp32_to_posit
  import posit_pkg::*;
#(
  parameter int N  = 32,
  parameter int ES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_fp,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_posit,
  output logic         out_nar
`ifdef FP32_TO_POSIT_INEXACT_EN
  ,
  output logic         out_inexact
`endif
);

  localparam int                        CAP     = (N - 2) << ES;
  localparam logic signed [SCALE_W-1:0] CAP_S   = SCALE_W'(CAP);
  localparam logic [63:0]               ST_MASK = (64'd1 << (63 - N)) - 64'd1;
  localparam logic [N-1:0]              MAXP    = N'(maxpos(N));
  localparam logic [N-1:0]              MINP    = N'(minpos(N));
  localparam logic [N-1:0]              NARP    = N'(nar_pat(N));

  logic    s1_valid, s2_valid, s3_valid;
  logic    s1_adv, s2_adv, s3_adv;
  unpack_t s1_d, s1_q;
  regime_t s2_d, s2_q;

  assign s3_adv    = out_ready | ~s3_valid;
  assign s2_adv    = ~s2_valid | s3_adv;
  assign s1_adv    = ~s1_valid | s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s3_valid;

  // ---------------- Stage 1: unpack and classify ----------------
  logic [7:0]        in_exp;
  logic [FRAC_W-1:0] in_frac;
  logic [4:0]        lz;

  assign in_exp  = in_fp[30:23];
  assign in_frac = in_fp[22:0];

  posit_lzc #(.W(FRAC_W)) u_lzc (
    .in_bits (in_frac),
    .count   (lz)
  );

  always_comb begin
    s1_d      = '0;
    s1_d.sign = in_fp[31];
    if (in_exp == 8'hFF)                      s1_d.cls = PC_NAR;
    else if (in_exp == 8'h00 && in_frac == '0) s1_d.cls = PC_ZERO;
    else                                      s1_d.cls = PC_NORM;
    if (in_exp == 8'h00) begin
      // Subnormal: leading one becomes the hidden bit
      s1_d.scale = -SCALE_W'(127) - SCALE_W'(lz);
      s1_d.frac  = (in_frac << lz) << 1;
    end else begin
      s1_d.scale = SCALE_W'(in_exp) - SCALE_W'(127);
      s1_d.frac  = in_frac;
    end
  end

  // ---------------- Stage 2: regime and saturation ----------------
  logic signed [SCALE_W-1:0] s1_scale, k;

  assign s1_scale = s1_q.scale;
  assign k        = s1_scale >>> ES;

  always_comb begin
    s2_d         = '0;
    s2_d.cls     = s1_q.cls;
    s2_d.sign    = s1_q.sign;
    s2_d.sat_max = (s1_scale > CAP_S);
    s2_d.sat_min = (s1_scale < -CAP_S);
    s2_d.k_neg   = k[SCALE_W-1];
    s2_d.run     = s2_d.k_neg ? RUN_W'(-k) : RUN_W'(k + 1);
    s2_d.e       = s1_scale[MAX_ES-1:0];
    s2_d.frac    = s1_q.frac;
  end

  // ---------------- Stage 3: pack and round ----------------
  logic [63:0]  tail, head, body;
  logic [N-2:0] mag;
  logic         g, r, st, ulp;
  logic [N-1:0] sum, mfin, posit_d;
  logic         nar_d;

  // Left-aligned {e, frac}; shifting drops the exponent bits above ES
  assign tail = {s2_q.e, s2_q.frac, 38'b0} << (MAX_ES - ES);
  assign head = s2_q.k_neg ? (64'h8000_0000_0000_0000 >> s2_q.run)
                           : ~({64{1'b1}} >> s2_q.run);
  assign body = head | (tail >> ({1'b0, s2_q.run} + 7'd1));
  assign mag  = body[63 -: N-1];
  assign g    = body[64-N];
  assign r    = body[63-N];
  assign st   = |(body & ST_MASK);
  assign ulp  = g & (r | st | mag[0]);
  assign sum  = {1'b0, mag} + N'(ulp);

`ifdef FP32_TO_POSIT_INEXACT_EN
  logic inexact_d;
`endif

  always_comb begin
    posit_d = '0;
    nar_d   = 1'b0;
    mfin    = '0;
`ifdef FP32_TO_POSIT_INEXACT_EN
    inexact_d = 1'b0;
`endif
    case (s2_q.cls)
      PC_NAR: begin
        posit_d = NARP;
        nar_d   = 1'b1;
      end
      PC_ZERO: posit_d = '0;
      default: begin
        if (s2_q.sat_max)      mfin = MAXP;
        else if (s2_q.sat_min) mfin = MINP;
        else if (sum[N-1])     mfin = MAXP;
        else if (sum == '0)    mfin = MINP;
        else                   mfin = {1'b0, sum[N-2:0]};
        posit_d = s2_q.sign ? (~mfin + N'(1)) : mfin;
`ifdef FP32_TO_POSIT_INEXACT_EN
        inexact_d = s2_q.sat_max | s2_q.sat_min | g | r | st;
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s3_valid  <= 1'b0;
      out_posit <= '0;
      out_nar   <= 1'b0;
`ifdef FP32_TO_POSIT_INEXACT_EN
      out_inexact <= 1'b0;
`endif
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_q <= s2_d;
      end
      if (s3_adv) begin
        s3_valid <= s2_valid;
        if (s2_valid) begin
          out_posit <= posit_d;
          out_nar   <= nar_d;
`ifdef FP32_TO_POSIT_INEXACT_EN
          out_inexact <= inexact_d;
`endif
        end
      end
    end
  end

endmodule : fp32_to_posit
`default_nettype wire

// File: tb/tb_fp32_to_posit.sv
`default_nettype none
// tb_fp32_to_posit : directed table + randomized stream against a bit-queue
// posit reference model, with a negedge scoreboard monitor.
module tb_fp32_to_posit;

  localparam int N  = 32;
  localparam int ES = 2;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, out_nar;
  logic [31:0]  in_fp;
  logic [N-1:0] out_posit;
`ifdef FP32_TO_POSIT_INEXACT_EN
  logic         out_inexact;
`endif

  always #5 clk = ~clk;

  fp32_to_posit #(.N(N), .ES(ES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fp     (in_fp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_posit (out_posit),
    .out_nar   (out_nar)
`ifdef FP32_TO_POSIT_INEXACT_EN
    ,
    .out_inexact (out_inexact)
`endif
  );

  typedef struct { logic [31:0] fp; logic [31:0] posit; logic nar; } vec_t;
  typedef struct { logic [31:0] posit; logic nar; int t; } exp_t;

  int          errors = 0, checks = 0, cyc = 0;
  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] cur_exp;
  logic        cur_nar;
  bit          lat_chk = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_posit;
  bit          stream_done;
  vec_t        tbl[15];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: build the posit bit string from regime/exponent/fraction rules
  function automatic void model(input logic [31:0] f, output logic [31:0] p, output logic nar);
    int     sc, kk, ee, useed_sh;
    longint m, mag, lim;
    bit     q[$];
    bit     g, rest;
    nar = 1'b0;
    useed_sh = 1 << ES;
    lim = longint'(1) << (N - 1);
    if (f[30:23] == 8'hFF) begin p = 32'h8000_0000; nar = 1'b1; return; end
    if (f[30:0] == 31'd0) begin p = 32'h0; return; end
    if (f[30:23] == 8'h00) begin sc = -126; m = longint'(f[22:0]); end
    else begin sc = int'(f[30:23]) - 127; m = longint'(f[22:0]) + (longint'(1) << 23); end
    while (m < (longint'(1) << 23)) begin m = m * 2; sc--; end
    if (sc > (N - 2) * useed_sh)       mag = lim - 1;
    else if (sc < -(N - 2) * useed_sh) mag = 1;
    else begin
      ee = ((sc % useed_sh) + useed_sh) % useed_sh;
      kk = (sc - ee) / useed_sh;
      if (kk >= 0) begin repeat (kk + 1) q.push_back(1'b1); q.push_back(1'b0); end
      else begin repeat (-kk) q.push_back(1'b0); q.push_back(1'b1); end
      for (int i = ES - 1; i >= 0; i--) q.push_back(ee[i]);
      for (int i = 22; i >= 0; i--) q.push_back(m[i]);
      while (q.size() < N + 1) q.push_back(1'b0);
      mag = 0;
      for (int i = 0; i < N - 1; i++) mag = mag * 2 + longint'(q[i]);
      g = q[N-1];
      rest = 1'b0;
      for (int i = N; i < q.size(); i++) rest |= q[i];
      if (g && (rest || mag[0])) mag++;
      if (mag >= lim) mag = lim - 1;
      if (mag == 0) mag = 1;
    end
    p = f[31] ? 32'(-mag) : 32'(mag);
  endfunction

  // Scoreboard monitor: transfers happen at the next posedge
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      check("in_ready", 64'(in_ready), 64'(!(sb.size() == 3 && !out_ready)));
      if (prev_stall) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_posit", 64'(out_posit), 64'(prev_posit));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out actual=0x%0h expected=no token", out_posit);
        end else begin
          mon_e = sb.pop_front();
          check("posit", 64'(out_posit), 64'(mon_e.posit));
          check("nar", 64'(out_nar), 64'(mon_e.nar));
          if (lat_chk) check("latency", 64'(cyc - mon_e.t), 64'd3);
        end
      end
      if (in_valid && in_ready) sb.push_back('{cur_exp, cur_nar, cyc});
      prev_stall = out_valid && !out_ready;
      prev_posit = out_posit;
    end
  end

  task automatic send(input logic [31:0] fp, input logic [31:0] ep, input logic en);
    int guard = 0;
    in_fp = fp; cur_exp = ep; cur_nar = en; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      guard++;
      if (guard > 200) begin
        checks++; errors++;
        $display("FAIL send_timeout actual=in_ready 0 expected=1");
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [31:0] fp, ep;
    logic        en;
    fp = $urandom;
    case ($urandom_range(0, 3))
      1: fp[30:23] = 8'($urandom_range(100, 150));
      2: fp[30:23] = 8'h00;
      3: fp[30:23] = 8'($urandom_range(240, 255));
      default: ;
    endcase
    model(fp, ep, en);
    send(fp, ep, en);
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    tbl[0]  = '{32'h3F80_0000, 32'h4000_0000, 1'b0};
    tbl[1]  = '{32'h4000_0000, 32'h4800_0000, 1'b0};
    tbl[2]  = '{32'h3F00_0000, 32'h3800_0000, 1'b0};
    tbl[3]  = '{32'hBF80_0000, 32'hC000_0000, 1'b0};
    tbl[4]  = '{32'h7FC0_0000, 32'h8000_0000, 1'b1};
    tbl[5]  = '{32'hFF80_0000, 32'h8000_0000, 1'b1};
    tbl[6]  = '{32'h8000_0000, 32'h0000_0000, 1'b0};
    tbl[7]  = '{32'h0000_0000, 32'h0000_0000, 1'b0};
    tbl[8]  = '{32'h7E96_7699, 32'h7FFF_FFFF, 1'b0};
    tbl[9]  = '{32'h0000_0001, 32'h0000_0001, 1'b0};
    tbl[10] = '{32'h8000_0001, 32'hFFFF_FFFF, 1'b0};
    tbl[11] = '{32'h3F80_0001, 32'h4000_0010, 1'b0};  // exact: 27 fraction bits available
    tbl[12] = '{32'h4980_0001, 32'h7E00_0000, 1'b0};  // tie, L=0 -> down
    tbl[13] = '{32'h4980_0003, 32'h7E00_0002, 1'b0};  // tie, L=1 -> up
    tbl[14] = '{32'hFF7F_FFFF, 32'h8000_0001, 1'b0};  // -maxfloat -> -maxpos

    rst = 1'b1; in_valid = 1'b0; in_fp = '0; out_ready = 1'b1;
    cur_exp = '0; cur_nar = 1'b0; stream_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_posit", 64'(out_posit), 64'd0);
    check("reset_out_nar", 64'(out_nar), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Directed table, back to back, no stalls
    lat_chk = 1'b1;
    for (int i = 0; i < 15; i++) send(tbl[i].fp, tbl[i].posit, tbl[i].nar);
    drain();
    lat_chk = 1'b0;

    // Back-pressure: 8 random operands under a fixed out_ready pattern
    pat = 8'b1001_0110;
    stream_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send_rand();
        stream_done = 1'b1;
      end
      begin
        int c = 0;
        while (!stream_done && c < 300) begin
          out_ready = pat[7 - (c % 8)];
          @(posedge clk); #1;
          c++;
        end
      end
    join
    drain();

    // Reset with 3 tokens in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_rand();
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_out_posit", 64'(out_posit), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_rand();
    drain();

    // Long random stream with random back-pressure
    stream_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) send_rand();
        stream_done = 1'b1;
      end
      begin
        int c = 0;
        while (!stream_done && c < 2000) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
          c++;
        end
      end
    join
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fp32_to_posit
`default_nettype wire
